// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequence monitor.
// Holds the FSM state enumeration, the four legal counter codes and the
// modulo-4 delta encodings used to classify a step.
package count_seq_pkg;

   localparam int unsigned CODE_W = 4;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned RUN_W  = 4;
   localparam int unsigned POS_W  = 8;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_ACQ    = 2'd1,
      ST_TRACK  = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   // Legal encodings of the external counter, one per index
   localparam logic [CODE_W-1:0] CODE_IDX0 = 4'b0000;
   localparam logic [CODE_W-1:0] CODE_IDX1 = 4'b0010;
   localparam logic [CODE_W-1:0] CODE_IDX2 = 4'b0100;
   localparam logic [CODE_W-1:0] CODE_IDX3 = 4'b0110;

   // (new_idx - prev_idx) mod 4
   localparam logic [IDX_W-1:0] DELTA_HOLD = 2'd0;
   localparam logic [IDX_W-1:0] DELTA_UP   = 2'd1;
   localparam logic [IDX_W-1:0] DELTA_SKIP = 2'd2;
   localparam logic [IDX_W-1:0] DELTA_DOWN = 2'd3;

endpackage

// File: rtl/count_code_decode.sv
// Combinational code table: maps a raw counter code to {valid, idx}.
// Ports:
//   value_in  4-bit raw code
//   valid_c   1 when value_in is one of the four legal codes
//   idx_c     index 0..3 of the legal code (0 when invalid)
module count_code_decode
   import count_seq_pkg::*;
(
   input  logic [CODE_W-1:0] value_in,
   output logic              valid_c,
   output logic [IDX_W-1:0]  idx_c
);

   always_comb begin
      valid_c = 1'b0;
      idx_c   = '0;
      case (value_in)
         CODE_IDX0: begin valid_c = 1'b1; idx_c = 2'd0; end
         CODE_IDX1: begin valid_c = 1'b1; idx_c = 2'd1; end
         CODE_IDX2: begin valid_c = 1'b1; idx_c = 2'd2; end
         CODE_IDX3: begin valid_c = 1'b1; idx_c = 2'd3; end
         default:   begin valid_c = 1'b0; idx_c = '0;   end
      endcase
   end

endmodule

// File: rtl/count_sequence_monitor.sv
// Monitors a 4-state encoded counter, classifies each sampled transition as
// up/down/hold/skip, tracks direction and lock, and keeps position and a
// saturating error count. All outputs are registered (latency 1).
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   sample_en    value_in is evaluated only when high
//   value_in     4-bit encoded counter value
//   dir_up       last resolved direction (1 = up)
//   dir_valid    a direction has been resolved since the last EMPTY/ACQ
//   locked       high while in LOCKED
//   step_pulse   one-cycle pulse per resolved step
//   dir_change   one-cycle pulse on a reversal while LOCKED
//   err_pulse    one-cycle pulse per invalid code or skip
//   err_count    saturating count of errors
//   pos          wrapping signed position
module count_sequence_monitor
   import count_seq_pkg::*;
#(
   parameter int unsigned LOCK_STEPS = 2,
   parameter int unsigned ERR_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_en,
   input  logic [3:0]       value_in,
   output logic             dir_up,
   output logic             dir_valid,
   output logic             locked,
   output logic             step_pulse,
   output logic             dir_change,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [7:0]       pos
);

   localparam logic [RUN_W-1:0] LOCK_CNT = RUN_W'(LOCK_STEPS);

   logic             code_valid_c;
   logic [IDX_W-1:0] code_idx_c;

   state_t           state_q, state_nxt;
   logic [IDX_W-1:0] prev_idx_q, prev_idx_nxt;
   logic [RUN_W-1:0] run_cnt_q, run_cnt_nxt;
   logic             dir_up_nxt, dir_valid_nxt;
   logic             step_pulse_nxt, dir_change_nxt, err_pulse_nxt;
   logic [ERR_W-1:0] err_count_nxt;
   logic [POS_W-1:0] pos_nxt;

   logic [IDX_W-1:0] delta_c;
   logic             step_up_c;
   logic             same_dir_c;
   logic [RUN_W-1:0] run_inc_c;

   count_code_decode u_decode (
      .value_in (value_in),
      .valid_c  (code_valid_c),
      .idx_c    (code_idx_c)
   );

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         prev_idx_q <= '0;
         run_cnt_q  <= '0;
         dir_up     <= 1'b0;
         dir_valid  <= 1'b0;
         locked     <= 1'b0;
         step_pulse <= 1'b0;
         dir_change <= 1'b0;
         err_pulse  <= 1'b0;
         err_count  <= '0;
         pos        <= '0;
      end else begin
         state_q    <= state_nxt;
         prev_idx_q <= prev_idx_nxt;
         run_cnt_q  <= run_cnt_nxt;
         dir_up     <= dir_up_nxt;
         dir_valid  <= dir_valid_nxt;
         locked     <= (state_nxt == ST_LOCKED);
         step_pulse <= step_pulse_nxt;
         dir_change <= dir_change_nxt;
         err_pulse  <= err_pulse_nxt;
         err_count  <= err_count_nxt;
         pos        <= pos_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt      = state_q;
      prev_idx_nxt   = prev_idx_q;
      run_cnt_nxt    = run_cnt_q;
      dir_up_nxt     = dir_up;
      dir_valid_nxt  = dir_valid;
      step_pulse_nxt = 1'b0;
      dir_change_nxt = 1'b0;
      err_pulse_nxt  = 1'b0;
      err_count_nxt  = err_count;
      pos_nxt        = pos;

      delta_c    = code_idx_c - prev_idx_q;
      step_up_c  = (delta_c == DELTA_UP);
      // Only a resolved direction can be continued; ACQ always starts a new run
      same_dir_c = dir_valid && (dir_up == step_up_c);
      run_inc_c  = run_cnt_q + RUN_W'(1);

      if (sample_en) begin
         if (!code_valid_c) begin
            err_pulse_nxt = 1'b1;
            dir_valid_nxt = 1'b0;
            run_cnt_nxt   = '0;
            state_nxt     = ST_EMPTY;
         end else if (state_q == ST_EMPTY) begin
            prev_idx_nxt = code_idx_c;
            state_nxt    = ST_ACQ;
         end else begin
            prev_idx_nxt = code_idx_c;
            case (delta_c)
               DELTA_SKIP: begin
                  err_pulse_nxt = 1'b1;
                  dir_valid_nxt = 1'b0;
                  run_cnt_nxt   = '0;
                  state_nxt     = ST_ACQ;
               end
               DELTA_UP, DELTA_DOWN: begin
                  step_pulse_nxt = 1'b1;
                  pos_nxt = step_up_c ? pos + POS_W'(1) : pos - POS_W'(1);
                  if (same_dir_c) begin
                     // LOCKED keeps its run count; TRACK counts toward lock
                     if (state_q == ST_TRACK) begin
                        run_cnt_nxt = run_inc_c;
                        state_nxt   = (run_inc_c >= LOCK_CNT) ? ST_LOCKED : ST_TRACK;
                     end
                  end else begin
                     run_cnt_nxt    = RUN_W'(1);
                     dir_up_nxt     = step_up_c;
                     dir_valid_nxt  = 1'b1;
                     dir_change_nxt = (state_q == ST_LOCKED);
                     state_nxt      = (LOCK_CNT == RUN_W'(1)) ? ST_LOCKED : ST_TRACK;
                  end
               end
               default: begin
               end
            endcase
         end

         if (err_pulse_nxt && (err_count != {ERR_W{1'b1}}))
            err_count_nxt = err_count + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_count_sequence_monitor.sv
// Self-checking bench for count_sequence_monitor: directed scenarios plus
// randomized samples, compared against a run-length based reference model.
module tb_count_sequence_monitor;

   localparam int unsigned LOCK_STEPS = 2;
   localparam int unsigned ERR_W      = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             sample_en;
   logic [3:0]       value_in;
   logic             dir_up, dir_valid, locked, step_pulse, dir_change, err_pulse;
   logic [ERR_W-1:0] err_count;
   logic [7:0]       pos;

   int checks = 0;
   int errors = 0;

   // Reference model: "have_prev" means a valid code has been seen since the
   // last reset/invalid code; run counts consecutive same-direction steps.
   bit m_have_prev;
   int m_prev;
   bit m_dir_valid;
   bit m_dir_up;
   int m_run;
   int m_err;
   int m_pos;
   bit m_step, m_dchg, m_errp;

   count_sequence_monitor #(.LOCK_STEPS(LOCK_STEPS), .ERR_W(ERR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .sample_en  (sample_en),
      .value_in   (value_in),
      .dir_up     (dir_up),
      .dir_valid  (dir_valid),
      .locked     (locked),
      .step_pulse (step_pulse),
      .dir_change (dir_change),
      .err_pulse  (err_pulse),
      .err_count  (err_count),
      .pos        (pos)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic bit m_locked();
      return m_dir_valid && (m_run >= int'(LOCK_STEPS));
   endfunction

   function automatic void model_reset();
      m_have_prev = 0; m_prev = 0; m_dir_valid = 0; m_dir_up = 0;
      m_run = 0; m_err = 0; m_pos = 0;
      m_step = 0; m_dchg = 0; m_errp = 0;
   endfunction

   function automatic void model_error();
      m_errp = 1;
      if (m_err < (1 << ERR_W) - 1) m_err++;
      m_dir_valid = 0;
      m_run = 0;
   endfunction

   function automatic void model_sample(input bit en, input int v);
      int idx, delta;
      bit up, was_locked;
      m_step = 0; m_dchg = 0; m_errp = 0;
      if (!en) return;
      if ((v % 2) != 0 || v >= 8) begin
         model_error();
         m_have_prev = 0;
         return;
      end
      idx = v / 2;
      if (!m_have_prev) begin
         m_have_prev = 1;
         m_prev = idx;
         return;
      end
      delta = (idx - m_prev + 4) % 4;
      m_prev = idx;
      if (delta == 2) begin
         model_error();
      end else if (delta != 0) begin
         up = (delta == 1);
         was_locked = m_locked();
         m_step = 1;
         m_pos = (m_pos + (up ? 1 : 255)) % 256;
         if (m_dir_valid && up == m_dir_up) begin
            m_run++;
         end else begin
            m_dchg = was_locked;
            m_run = 1;
            m_dir_up = up;
            m_dir_valid = 1;
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".dir_up"},     32'(dir_up),     32'(m_dir_up));
      chk({ctx, ".dir_valid"},  32'(dir_valid),  32'(m_dir_valid));
      chk({ctx, ".locked"},     32'(locked),     32'(m_locked()));
      chk({ctx, ".step_pulse"}, 32'(step_pulse), 32'(m_step));
      chk({ctx, ".dir_change"}, 32'(dir_change), 32'(m_dchg));
      chk({ctx, ".err_pulse"},  32'(err_pulse),  32'(m_errp));
      chk({ctx, ".err_count"},  32'(err_count),  32'(m_err));
      chk({ctx, ".pos"},        32'(pos),        32'(m_pos));
   endtask

   task automatic sample(input bit en, input logic [3:0] v, input string ctx);
      sample_en = en;
      value_in  = v;
      model_sample(en, int'(v));
      @(posedge clk); #1;
      sample_en = 1'b0;
      check_all(ctx);
   endtask

   task automatic do_reset(input bit en, input logic [3:0] v, input string ctx);
      reset     = 1'b1;
      sample_en = en;
      value_in  = v;
      model_reset();
      @(posedge clk); #1;
      check_all(ctx);
      chk({ctx, ".zero_outputs"},
          32'({dir_up, dir_valid, locked, step_pulse, dir_change, err_pulse, err_count, pos}), 32'd0);
      reset     = 1'b0;
      sample_en = 1'b0;
   endtask

   initial begin
      logic [3:0] rv;
      bit         ren;
      reset = 1'b0; sample_en = 1'b0; value_in = '0;
      model_reset();
      #1;

      // Reset state
      do_reset(1'b0, 4'b0000, "reset");

      // Lock up: 0000, 0010, 0100
      sample(1, 4'b0000, "acq");
      sample(1, 4'b0010, "up1");
      sample(1, 4'b0100, "up2");
      chk("lock_up.locked", 32'(locked), 32'd1);
      chk("lock_up.pos",    32'(pos),    32'd2);

      // Reversal while locked
      sample(1, 4'b0010, "reverse");
      chk("reverse.dir_change", 32'(dir_change), 32'd1);
      chk("reverse.pos",        32'(pos),        32'd1);

      // Skip, then invalid code
      sample(1, 4'b0000, "down");
      sample(1, 4'b0100, "skip");
      chk("skip.err_count", 32'(err_count), 32'd1);
      sample(1, 4'b0101, "invalid");
      sample(1, 4'b0101, "invalid_empty");

      // Holds and disabled cycles produce nothing
      sample(1, 4'b0110, "reacq");
      sample(1, 4'b0110, "hold1");
      sample(1, 4'b0110, "hold2");
      sample(0, 4'b0000, "idle_skip");
      sample(0, 4'b1111, "idle_bad");
      sample(1, 4'b0000, "up_wrap_idx");

      // Reset collides with a sample while locked
      do_reset(1'b0, 4'b0000, "reset2");
      sample(1, 4'b0000, "l_acq");
      sample(1, 4'b0010, "l_up1");
      sample(1, 4'b0100, "l_up2");
      do_reset(1'b1, 4'b0110, "reset_vs_sample");
      sample(1, 4'b0110, "post_reset_acq");
      for (int i = 0; i < 3; i++) sample(1, 4'b0110, "repeat_hold");

      // 130 up steps from reset: position wraps past +127
      do_reset(1'b0, 4'b0000, "reset3");
      for (int i = 0; i <= 130; i++) sample(1, 4'((i % 4) * 2), "wrap_up");
      chk("wrap.pos", 32'(pos), 32'h82);

      // Error counter saturation
      for (int i = 0; i < 300; i++) sample(1, 4'b0001, "err_sat");
      chk("sat.err_count", 32'(err_count), 32'hFF);

      // Randomized samples with occasional resets
      do_reset(1'b0, 4'b0000, "reset4");
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 60) == 0) begin
            do_reset(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rand_reset");
         end else begin
            ren = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) rv = 4'($urandom_range(0, 15));
            else rv = 4'($urandom_range(0, 3) * 2);
            sample(ren, rv, "rand");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_sequence_monitor.md
COUNT_SEQUENCE_MONITOR -- requirements
Module: count_sequence_monitor

Interface
REQ-001 Parameter LOCK_STEPS, default 2, meaning: consecutive same-direction steps needed to assert locked; legal range 1..15.
REQ-002 Parameter ERR_W, default 8, meaning: width of the saturating error counter.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clock clk.
REQ-005 sample_en  input  1  synchronous strobe; value_in is evaluated only in cycles where it is 1.
REQ-006 value_in  input  4  encoded counter value: 4'b0000=idx0, 4'b0010=idx1, 4'b0100=idx2, 4'b0110=idx3; all other codes are invalid.
REQ-007 dir_up  output  1  last resolved step direction, 1=up, 0=down.
REQ-008 dir_valid  output  1  at least one step has been resolved since the last EMPTY/ACQ state.
REQ-009 locked  output  1  high only in state LOCKED.
REQ-010 step_pulse  output  1  one-cycle pulse per resolved up or down step.
REQ-011 dir_change  output  1  one-cycle pulse when a reversal is seen in LOCKED.
REQ-012 err_pulse  output  1  one-cycle pulse per invalid code or skip.
REQ-013 err_count  output  ERR_W  saturating count of err_pulse events.
REQ-014 pos  output  8  wrapping two's-complement position, +1 per up step, -1 per down step.

Function
REQ-015 Every output SHALL be registered; response to a sample appears on the cycle after the sample_en cycle (latency 1); pulses last exactly one cycle.
REQ-016 The block SHALL keep prev_idx (2 bits); on a valid sample delta = (new_idx - prev_idx) mod 4: 1=up step, 3=down step, 0=hold, 2=skip; prev_idx SHALL be updated to new_idx on every valid sample.
REQ-017 States SHALL be EMPTY, ACQ, TRACK, LOCKED; internal run counter run_cnt 4 bits.
REQ-018 EMPTY: valid code -> ACQ; invalid code -> err_pulse, stay EMPTY.
REQ-019 ACQ: up/down step -> TRACK, run_cnt=1, dir_up set, dir_valid=1, step_pulse; if LOCK_STEPS=1 -> LOCKED directly instead.
REQ-020 TRACK: step in same direction -> run_cnt+1, step_pulse; when run_cnt reaches LOCK_STEPS -> LOCKED; reversal -> run_cnt=1, dir_up updated, step_pulse, stay TRACK (no dir_change).
REQ-021 LOCKED: same-direction step -> step_pulse, stay; reversal -> step_pulse, dir_change, dir_up updated, TRACK with run_cnt=1 (or stay LOCKED when LOCK_STEPS=1).
REQ-022 Hold (delta 0) in any state SHALL change nothing except prev_idx (unchanged anyway); no pulse.
REQ-023 Skip (delta 2) in ACQ/TRACK/LOCKED -> err_pulse, dir_valid=0, run_cnt=0, state ACQ with prev_idx=new_idx; pos unchanged.
REQ-024 Invalid code in ACQ/TRACK/LOCKED -> err_pulse, dir_valid=0, run_cnt=0, state EMPTY; prev_idx unchanged.
REQ-025 err_count SHALL saturate at 2^ERR_W-1; pos SHALL wrap 127->-128 (8'h7F->8'h80) and -128->127.
REQ-026 sample_en=0 cycles SHALL leave all state unchanged and all pulses low.

Reset
REQ-027 Reset SHALL dominate all other inputs, including a concurrent sample_en.
REQ-028 Reset values: state EMPTY, prev_idx 0, run_cnt 0, dir_up 0, dir_valid 0, locked 0, all pulses 0, err_count 0, pos 0.
REQ-029 Reset asserted mid-track SHALL discard history; the first sample after release is treated as in EMPTY.

Structure
REQ-030 Shared package count_seq_pkg SHALL hold the state enumeration, the four valid code constants and the delta encodings.
REQ-031 One combinational sub-module count_code_decode SHALL map value_in to {valid, idx[1:0]}; it is the only place the code table is written.

Verification
REQ-032 Reset, then samples 0000,0010,0100 (LOCK_STEPS=2) -> after third sample locked=1, dir_up=1, pos=2, two step_pulses.
REQ-033 Locked up, then sample 0010 after 0100 -> dir_change pulse, dir_up=0, locked=0, pos decremented by 1.
REQ-034 Sample 0000 then 0100 (skip) -> err_pulse, err_count=1, state ACQ, pos unchanged; invalid 0101 -> err_pulse, state EMPTY.
REQ-035 256+ invalid samples with ERR_W=8 -> err_count holds at 8'hFF; 130 up steps from reset -> pos wraps to 8'h82.
REQ-036 Reset asserted in the same cycle as a valid sample_en while LOCKED -> all outputs at reset values next cycle; repeated identical codes produce no pulses.
